// File: rtl/dcache_line_mover.sv
// Moves one aligned cache line between the D-cache and the data RAM: refill streams RAM words out on rd_*,
// writeback pulls words in via wr_idx/wr_word. N+1 busy cycles per line; requests are only taken when idle.
module dcache_line_mover #(
   parameter int LINE_WORDS = 8,
   parameter int MEM_AW     = 12
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [29:0]                   req_addr,
   output logic [$clog2(LINE_WORDS)-1:0] wr_idx,
   input  logic [31:0]                   wr_word,
   output logic                          rd_valid,
   output logic [$clog2(LINE_WORDS)-1:0] rd_idx,
   output logic [31:0]                   rd_word,
   output logic                          done,
   output logic                          err,
   output logic [29:0]                   mem_addr,
   output logic [3:0]                    mem_write_en,
   output logic [31:0]                   mem_in_data,
   input  logic [31:0]                   mem_out_data
);

   localparam int IW = $clog2(LINE_WORDS);
   localparam logic [29:0] LINE_MASK = 30'(LINE_WORDS - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [29:0]     base_q, base_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic            last_rd_q, last_rd_d;
   logic            err_q, err_d;
   logic [29:0]     word_addr;

   // Base is line-aligned, so OR-ing the index in can never carry out of the line.
   assign word_addr = base_q | {{(30-IW){1'b0}}, cnt_q};
   assign rd_word   = mem_out_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         cnt_q     <= '0;
         last_rd_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         last_rd_q <= last_rd_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      last_rd_d = last_rd_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               base_d = req_addr & ~LINE_MASK;
               cnt_d  = '0;
               if ((req_addr >> MEM_AW) != 30'd0) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = req_write ? S_WRITE : S_READ;
               end
            end
         end
         S_READ: begin
            cnt_d = cnt_q + IW'(1);
            if (cnt_q == LAST_IDX) begin
               state_d   = S_DONE;
               last_rd_d = 1'b1;
            end
         end
         S_WRITE: begin
            cnt_d = cnt_q + IW'(1);
            if (cnt_q == LAST_IDX) begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            last_rd_d = 1'b0;
            err_d     = 1'b0;
         end
      endcase
   end

   always_comb begin
      req_ready    = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      rd_valid     = 1'b0;
      rd_idx       = '0;
      mem_addr     = '0;
      mem_write_en = 4'h0;
      mem_in_data  = '0;
      wr_idx       = '0;
      case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_READ: begin
            mem_addr = word_addr;
            // RAM data lags the address by one cycle, so the index trails cnt.
            rd_valid = (cnt_q != '0);
            rd_idx   = cnt_q - IW'(1);
         end
         S_WRITE: begin
            mem_addr     = word_addr;
            mem_write_en = 4'hF;
            wr_idx       = cnt_q;
            mem_in_data  = wr_word;
         end
         default: begin
            done     = 1'b1;
            err      = err_q;
            rd_valid = last_rd_q;
            rd_idx   = last_rd_q ? LAST_IDX : '0;
         end
      endcase
   end

endmodule
